// File: rtl/ann_frame_sequencer.sv
// ann_frame_sequencer: assembles feature frames, runs the ANN handshake, reports argmax class and drowsiness alarm
module ann_frame_sequencer #(
  parameter int W            = 10,
  parameter int N_FEAT       = 30,
  parameter int N_OUT        = 3,
  parameter int ARM_CYCLES   = 4,
  parameter int TIMEOUT      = 4096,
  parameter int DROWSY_CLASS = 2,
  parameter int ALARM_FRAMES = 3
) (
  input  logic         Clock,
  input  logic         Rst,
  input  logic [W-1:0] sample_in,
  input  logic         sample_sof,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic [W-1:0] feat_out [N_FEAT-1:0],
  output logic         ann_start,
  input  logic         ann_done,
  input  logic [W-1:0] ann_out [N_OUT-1:0],
  output logic         class_valid,
  output logic [1:0]   class_id,
  output logic [W-1:0] class_score,
  output logic         drowsy_alarm,
  output logic         busy,
  output logic         frame_err
);
  localparam int IW = $clog2(N_FEAT);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(ALARM_FRAMES + 1);
  typedef enum logic [2:0] {IDLE, FILL, ARM, RUN, CAPTURE, REPORT} state_t;
  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] run_q, run_d;
  logic          armed_q, start_q, valid_q, err_q, alarm_q;
  logic [W-1:0]  feat_q [N_FEAT-1:0];
  logic [W-1:0]  cap_q [N_OUT-1:0];
  logic [1:0]    id_q, best_id_d;
  logic [W-1:0]  score_q, best_score_d;
  logic          accept;
  assign sample_ready = (state_q == IDLE) || (state_q == FILL);
  assign accept       = sample_valid && sample_ready;
  assign busy         = (state_q == ARM) || (state_q == RUN) || (state_q == CAPTURE);
  assign feat_out     = feat_q;
  assign ann_start    = start_q;
  assign class_valid  = valid_q;
  assign class_id     = id_q;
  assign class_score  = score_q;
  assign drowsy_alarm = alarm_q;
  assign frame_err    = err_q;
  // strict > keeps the lowest index on ties
  always_comb begin
    best_id_d    = '0;
    best_score_d = cap_q[0];
    for (int k = 1; k < N_OUT; k++)
      if (cap_q[k] > best_score_d) begin
        best_id_d    = 2'(k);
        best_score_d = cap_q[k];
      end
    run_d = (best_id_d != 2'(DROWSY_CLASS)) ? '0 :
            (run_q == RW'(ALARM_FRAMES)) ? run_q : run_q + RW'(1);
  end
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
      id_q    <= '0;
      score_q <= '0;
      feat_q  <= '{default: '0};
      cap_q   <= '{default: '0};
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (sample_sof) begin
            feat_q[0] <= sample_in;
            idx_q     <= IW'(1);
            state_q   <= FILL;
          end else err_q <= 1'b1;
        end
        FILL: if (accept) begin
          feat_q[sample_sof ? IW'(0) : idx_q] <= sample_in;
          idx_q <= sample_sof ? IW'(1) : idx_q + IW'(1);
          if (!sample_sof && idx_q == IW'(N_FEAT - 1)) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= ARM;
          end
        end
        ARM: if (cnt_q == CW'(ARM_CYCLES - 1)) begin
          cnt_q   <= '0;
          armed_q <= 1'b0;
          start_q <= 1'b1;
          state_q <= RUN;
        end else cnt_q <= cnt_q + CW'(1);
        // done only counts after it has been seen low in this run
        RUN: if (ann_done && armed_q) state_q <= CAPTURE;
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          start_q <= 1'b0;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
          if (!ann_done) armed_q <= 1'b1;
        end
        CAPTURE: begin
          cap_q   <= ann_out;
          state_q <= REPORT;
        end
        REPORT: begin
          valid_q <= 1'b1;
          id_q    <= best_id_d;
          score_q <= best_score_d;
          run_q   <= run_d;
          alarm_q <= run_d == RW'(ALARM_FRAMES);
          start_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
